// File: rtl/cic_pkg.sv
// Shared types and default sizing for the CIC decimator control slice.
package cic_pkg;

    localparam int unsigned CIC_N_STAGES = 3;
    localparam int unsigned CIC_RATE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } cic_state_e;

endpackage

// File: rtl/cic_mod_counter.sv
// Modulo counter: counts enabled cycles 0..mod-1 and flags the wrapping cycle.
module cic_mod_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_mod,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == (i_mod - W'(1)));
    assign o_wrap = i_en && w_last;

    // Count enabled cycles; clear has priority over counting.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Control sequencer for a CIC decimator: flush, decimation timing, warm-up
// masking and output handshake. Carries no sample data.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned N_STAGES = CIC_N_STAGES,
    parameter int unsigned RATE_W   = CIC_RATE_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [RATE_W-1:0] i_rate,
    input  logic              i_sample_valid,
    output logic              o_int_en,
    output logic              o_int_rst,
    output logic              o_comb_en,
    output logic              o_comb_rst,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int unsigned FL_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int unsigned WM_W = $clog2(N_STAGES + 1);

    cic_state_e        r_state;
    cic_state_e        w_next;
    logic [FL_W-1:0]   r_flush_cnt;
    logic [WM_W-1:0]   r_warm;
    logic [RATE_W-1:0] r_rate;
    logic              r_out_valid;
    logic              r_overrun;

    logic w_start;
    logic w_abort;
    logic w_accept;
    logic w_wrap;
    logic w_warm;
    logic w_set_valid;
    logic w_cnt_clr;

    assign w_start     = (r_state == ST_IDLE) && i_start && !i_stop;
    assign w_abort     = (r_state != ST_IDLE) && i_stop;
    assign w_accept    = (r_state == ST_RUN) && i_sample_valid && !i_rst;
    assign w_cnt_clr   = w_start || w_abort;
    assign w_warm      = (r_warm == WM_W'(N_STAGES));
    assign w_set_valid = w_wrap && w_warm;

    assign o_busy      = (r_state != ST_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;

    cic_mod_counter #(
        .W (RATE_W)
    ) u_dec_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_accept),
        .i_clr  (w_cnt_clr),
        .i_mod  (r_rate),
        .o_wrap (w_wrap)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and chain enables/clears; reset forces everything quiet.
    always_comb begin
        w_next     = r_state;
        o_int_en   = 1'b0;
        o_int_rst  = 1'b0;
        o_comb_en  = 1'b0;
        o_comb_rst = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                o_int_en   = 1'b1;
                o_int_rst  = 1'b1;
                o_comb_rst = 1'b1;
                if (i_stop) begin
                    w_next = ST_IDLE;
                end else if (r_flush_cnt == FL_W'(N_STAGES - 1)) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_int_en  = i_sample_valid;
                o_comb_en = w_wrap;
                if (i_stop) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (i_rst) begin
            w_next     = ST_IDLE;
            o_int_en   = 1'b0;
            o_int_rst  = 1'b0;
            o_comb_en  = 1'b0;
            o_comb_rst = 1'b0;
        end
    end

    // Flush duration counter, only advances while flushing.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != ST_FLUSH) begin
            r_flush_cnt <= '0;
        end else begin
            r_flush_cnt <= r_flush_cnt + FL_W'(1);
        end
    end

    // Latch the ratio on start, promoting 0 and 1 to 2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rate <= '0;
        end else if (w_start) begin
            r_rate <= (i_rate < RATE_W'(2)) ? RATE_W'(2) : i_rate;
        end
    end

    // Warm-up: count comb pulses until the comb pipeline holds valid history.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_cnt_clr) begin
            r_warm <= '0;
        end else if (w_wrap && !w_warm) begin
            r_warm <= r_warm + WM_W'(1);
        end
    end

    // Output valid handshake; a new result while one is pending flags overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_cnt_clr) begin
            r_out_valid <= 1'b0;
            if (w_start) r_overrun <= 1'b0;
        end else if (w_set_valid) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !i_out_ready) r_overrun <= 1'b1;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with a small behavioural reference model.
module tb_cic_decim_ctrl;

    localparam int unsigned N = 3;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic       i_stop;
    logic [7:0] i_rate;
    logic       i_sample_valid;
    logic       o_int_en;
    logic       o_int_rst;
    logic       o_comb_en;
    logic       o_comb_rst;
    logic       o_out_valid;
    logic       i_out_ready;
    logic       o_busy;
    logic       o_overrun;

    int n_checks = 0;
    int n_err    = 0;

    int m_rate, m_cnt, m_warm, m_valid, m_ovr;
    int g_run_cyc, g_first_valid;

    cic_decim_ctrl #(
        .N_STAGES (N),
        .RATE_W   (8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_rate         (i_rate),
        .i_sample_valid (i_sample_valid),
        .o_int_en       (o_int_en),
        .o_int_rst      (o_int_rst),
        .o_comb_en      (o_comb_en),
        .o_comb_rst     (o_comb_rst),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // All enables/clears low and not busy (IDLE), sampled with strobe high.
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},     32'(o_busy), 0);
        chk({tag, "_int_en"},   32'(o_int_en), 0);
        chk({tag, "_int_rst"},  32'(o_int_rst), 0);
        chk({tag, "_comb_en"},  32'(o_comb_en), 0);
        chk({tag, "_comb_rst"}, 32'(o_comb_rst), 0);
        chk({tag, "_valid"},    32'(o_out_valid), 0);
    endtask

    // Start from IDLE and walk through the flush window.
    task automatic do_start(input logic [7:0] rate);
        i_start = 1'b1;
        i_rate  = rate;
        i_sample_valid = 1'b1;
        #1;
        chk_idle("start_cyc");
        tick();
        i_start = 1'b0;
        i_rate  = 8'd1;
        m_rate  = (rate < 8'd2) ? 2 : int'(rate);
        m_cnt = 0; m_warm = 0; m_valid = 0; m_ovr = 0;
        g_run_cyc = 0; g_first_valid = 0;
        for (int f = 0; f < int'(N); f++) begin
            i_sample_valid = 1'(f % 2);
            #1;
            chk("flush_busy",     32'(o_busy), 1);
            chk("flush_int_en",   32'(o_int_en), 1);
            chk("flush_int_rst",  32'(o_int_rst), 1);
            chk("flush_comb_rst", 32'(o_comb_rst), 1);
            chk("flush_comb_en",  32'(o_comb_en), 0);
            chk("flush_overrun",  32'(o_overrun), 0);
            tick();
        end
    endtask

    // RUN cycles checked against the reference model; mode 0 continuous, 1 alternate.
    task automatic run_cycles(input int n, input int mode, input logic rdy);
        int acc, exp_comb, setv;
        for (int i = 0; i < n; i++) begin
            g_run_cyc++;
            i_sample_valid = (mode == 0) ? 1'b1 : 1'(g_run_cyc % 2);
            i_out_ready    = rdy;
            #1;
            acc      = int'(i_sample_valid);
            exp_comb = (acc == 1 && m_cnt == m_rate - 1) ? 1 : 0;
            chk("run_int_en",  32'(o_int_en), acc);
            chk("run_comb_en", 32'(o_comb_en), exp_comb);
            chk("run_valid",   32'(o_out_valid), m_valid);
            chk("run_overrun", 32'(o_overrun), m_ovr);
            chk("run_clears",  32'(o_int_rst | o_comb_rst), 0);
            chk("run_busy",    32'(o_busy), 1);
            if (o_out_valid && g_first_valid == 0) g_first_valid = g_run_cyc;
            setv = (exp_comb == 1 && m_warm == int'(N)) ? 1 : 0;
            if (exp_comb == 1) begin
                m_cnt = 0;
                if (m_warm < int'(N)) m_warm++;
            end else if (acc == 1) begin
                m_cnt++;
            end
            if (setv == 1) begin
                if (m_valid == 1 && !rdy) m_ovr = 1;
                m_valid = 1;
            end else if (m_valid == 1 && rdy) begin
                m_valid = 0;
            end
            tick();
        end
    endtask

    task automatic do_stop();
        i_stop = 1'b1;
        #1;
        tick();
        i_stop = 1'b0;
        i_sample_valid = 1'b1;
        i_rate = 8'd9;
        #1;
        chk_idle("after_stop");
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_rate = 8'd4;
        i_sample_valid = 1'b1; i_out_ready = 1'b1;
        m_rate = 2; m_cnt = 0; m_warm = 0; m_valid = 0; m_ovr = 0;
        g_run_cyc = 0; g_first_valid = 0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_overrun", 32'(o_overrun), 0);
        i_rst = 1'b0;
        tick();

        // R=4 continuous, ready high: first valid at RUN cycle 17.
        do_start(8'd4);
        run_cycles(40, 0, 1'b1);
        chk("first_valid_r4", g_first_valid, 17);
        do_stop();

        // R=0 and R=1 behave as R=2: 3 warm-up pulses then valid at cycle 9.
        do_start(8'd0);
        run_cycles(16, 0, 1'b1);
        chk("first_valid_r0", g_first_valid, 9);
        do_stop();
        do_start(8'd1);
        run_cycles(12, 0, 1'b1);
        chk("first_valid_r1", g_first_valid, 9);
        do_stop();

        // Alternating strobe, R=4: pulse every 8 cycles, first valid at cycle 32.
        do_start(8'd4);
        run_cycles(40, 1, 1'b1);
        chk("first_valid_alt", g_first_valid, 32);
        do_stop();

        // Overrun: consumer stalls across two more results.
        do_start(8'd4);
        run_cycles(16, 0, 1'b1);
        run_cycles(8, 0, 1'b0);
        chk("ovr_set",   32'(o_overrun), 1);
        chk("ovr_valid", 32'(o_out_valid), 1);
        run_cycles(2, 0, 1'b1);
        chk("ovr_drain_valid", 32'(o_out_valid), 0);
        chk("ovr_sticky",      32'(o_overrun), 1);
        do_stop();
        chk("ovr_after_stop", 32'(o_overrun), 1);

        // Start and stop together: stop wins.
        i_start = 1'b1; i_stop = 1'b1;
        #1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        #1;
        chk_idle("start_stop");
        chk("start_stop_ovr", 32'(o_overrun), 1);

        // Stop mid-RUN with a pending result (start also clears overrun).
        do_start(8'd4);
        run_cycles(17, 0, 1'b0);
        chk("pend_valid", 32'(o_out_valid), 1);
        do_stop();
        chk("stop_ovr", 32'(o_overrun), 0);

        // Reset mid-RUN overrides a simultaneous start and drops the result.
        do_start(8'd4);
        run_cycles(17, 0, 1'b0);
        i_rst = 1'b1; i_start = 1'b1; i_sample_valid = 1'b1;
        #1;
        chk("rst_gate_int_en", 32'(o_int_en), 0);
        tick();
        chk_idle("mid_rst");
        chk("mid_rst_ovr", 32'(o_overrun), 0);
        i_rst = 1'b0; i_start = 1'b0;
        #1;
        chk("post_rst_busy", 32'(o_busy), 0);
        tick();
        do_start(8'd4);
        run_cycles(25, 0, 1'b1);
        chk("first_valid_restart", g_first_valid, 17);
        do_stop();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 3: number of integrator and comb stages sequenced.
REQ-002 SHALL have parameter RATE_W, default 8: width of the decimation-ratio input.
REQ-003 SHALL have port i_clk, input, 1: clock; all logic on posedge.
REQ-004 SHALL have port i_rst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: start request, sampled in IDLE.
REQ-006 SHALL have port i_stop, input, 1: abort request, any state.
REQ-007 SHALL have port i_rate, input, RATE_W: decimation ratio R, latched on start.
REQ-008 SHALL have port i_sample_valid, input, 1: modulator sample strobe.
REQ-009 SHALL have port o_int_en, output, 1: integrator-chain enable.
REQ-010 SHALL have port o_int_rst, output, 1: integrator-chain clear; effective only with o_int_en.
REQ-011 SHALL have port o_comb_en, output, 1: comb-chain enable, one-cycle pulse.
REQ-012 SHALL have port o_comb_rst, output, 1: comb-chain clear.
REQ-013 SHALL have port o_out_valid, output, 1: decimated output available.
REQ-014 SHALL have port i_out_ready, input, 1: consumer accepts output.
REQ-015 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port o_overrun, output, 1: sticky; a decimated output was lost.

Function
REQ-017 SHALL implement the states IDLE, FLUSH and RUN.
REQ-018 SHALL move from IDLE to FLUSH when i_start=1 and i_stop=0; i_stop SHALL win if both are high in the same cycle.
REQ-019 SHALL latch R on the start cycle; R<2 SHALL be treated as 2.
REQ-020 SHALL clear o_overrun, the decimation counter and the warm-up counter on the start cycle.
REQ-021 SHALL hold FLUSH for exactly N_STAGES cycles, then enter RUN.
REQ-022 In FLUSH, o_int_en, o_int_rst and o_comb_rst SHALL be 1 and o_comb_en SHALL be 0.
REQ-023 In FLUSH, i_sample_valid SHALL be ignored and not counted.
REQ-024 In RUN, o_int_en SHALL equal i_sample_valid combinationally, and o_int_rst and o_comb_rst SHALL be 0.
REQ-025 The decimation counter SHALL count accepted samples 0..R-1 and wrap to 0.
REQ-026 o_comb_en SHALL pulse in the cycle a sample is accepted with the counter at R-1.
REQ-027 The warm-up counter SHALL count comb pulses, saturating at N_STAGES.
REQ-028 Comb pulses issued while warm-up is below N_STAGES SHALL NOT raise o_out_valid.
REQ-029 Once warm, o_out_valid SHALL rise one cycle after o_comb_en and hold until i_out_ready=1.
REQ-030 o_out_valid SHALL clear in the cycle after any cycle with o_out_valid=1 and i_out_ready=1.
REQ-031 If a new valid-setting pulse coincides with a handshake, valid SHALL stay 1.
REQ-032 If a new valid-setting pulse arrives while o_out_valid=1 and i_out_ready=0, o_overrun SHALL set, valid SHALL stay 1, and the count SHALL continue.
REQ-033 i_stop in FLUSH or RUN SHALL go to IDLE next cycle, clearing o_out_valid and the counters and deasserting all enables.
REQ-034 o_overrun SHALL hold through stop and clear only on reset or start.
REQ-035 In IDLE, all enables and clears SHALL be 0, and changes on i_rate SHALL be ignored.

Reset
REQ-036 While i_rst=1, the state SHALL be IDLE, all counters 0, and all outputs 0.
REQ-037 Reset SHALL override start and stop, and reset mid-RUN SHALL drop any pending output.

Structure
REQ-038 Package cic_pkg SHALL hold the state enum and the N_STAGES and RATE_W defaults.
REQ-039 The decimation counter SHALL be the sub-module cic_mod_counter (enable, clear, modulus, wrap pulse).
REQ-040 The implementation SHALL contain no datapath and no storage of sample values.

Verification
REQ-041 N_STAGES=3, R=4, continuous samples, ready=1 -> FLUSH 3 cycles; comb pulses every 4th sample; first valid follows the 4th pulse; then one valid every 4 samples.
REQ-042 R=0 and R=1 -> behave as R=2 (comb pulse every 2nd sample).
REQ-043 i_sample_valid toggled 1010... with R=4 -> comb pulse every 8 cycles; o_int_en mirrors the strobe.
REQ-044 ready=0 after first valid, next pulse arrives -> o_overrun=1, valid held; ready=1 -> valid clears; overrun stays 1.
REQ-045 i_start and i_stop in same cycle -> remains IDLE; i_stop mid-RUN with valid pending -> IDLE next cycle, valid=0, o_busy=0.
REQ-046 i_rst mid-RUN -> all outputs 0 next cycle; restart reproduces the warm-up of REQ-041.
